// File: rtl/iir_decimator_fifo.sv
// Boxcar-averages every 2^DECIM_LOG2 valid samples into a show-ahead FIFO; avg visible 1 cycle after last sample.
// Backpressure: out_valid/out_ready drain; a full FIFO without a same-cycle pop drops the average and sets sticky overflow.
module iir_decimator_fifo #(
   parameter int DECIM_LOG2  = 6,
   parameter int FIFO_ADDR_W = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     data_valid,
   input  logic signed [63:0]       data,
   input  logic                     out_ready,
   output logic signed [63:0]       out_data,
   output logic                     out_valid,
   output logic [FIFO_ADDR_W:0]     fifo_level,
   output logic                     overflow,
   output logic [DECIM_LOG2:0]      sample_cnt
);

   localparam int ACC_W = 64 + DECIM_LOG2;
   localparam int DEPTH = 2 ** FIFO_ADDR_W;
   localparam logic [DECIM_LOG2:0]    CNT_LAST = (DECIM_LOG2 + 1)'(2 ** DECIM_LOG2 - 1);
   localparam logic [DECIM_LOG2:0]    CNT_ONE  = (DECIM_LOG2 + 1)'(1);
   localparam logic [FIFO_ADDR_W:0]   LVL_FULL = (FIFO_ADDR_W + 1)'(DEPTH);
   localparam logic [FIFO_ADDR_W:0]   LVL_ONE  = (FIFO_ADDR_W + 1)'(1);
   localparam logic [FIFO_ADDR_W-1:0] PTR_ONE  = FIFO_ADDR_W'(1);

   logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
   logic [DECIM_LOG2:0]      cnt_q, cnt_d;
   logic [FIFO_ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [FIFO_ADDR_W:0]     level_q, level_d;
   logic signed [63:0]       head_q, head_d, avg;
   logic                     overflow_q, overflow_d;
   logic                     enable_q, enable_d;
   logic                     push, pop, full, wr_en;
   logic signed [63:0]       mem [DEPTH];

   always_comb begin
      sum      = acc_q + ACC_W'(data);
      avg      = 64'(sum >>> DECIM_LOG2);
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      enable_d = enable;
      if (!enable) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (data_valid) begin
         if (cnt_q == CNT_LAST) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      pop      = (level_q != '0) && out_ready;
      full     = (level_q == LVL_FULL);
      // When full, a same-cycle pop frees the slot the write lands in.
      wr_en    = push && (!full || pop);
      rd_next  = rd_ptr_q + PTR_ONE;
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_next : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop)
         level_d = level_q + LVL_ONE;
      else if (!wr_en && pop)
         level_d = level_q - LVL_ONE;

      // Head is registered so it holds its last value once the FIFO empties.
      head_d = head_q;
      if (pop) begin
         if (level_q == LVL_ONE)
            head_d = wr_en ? avg : head_q;
         else
            head_d = mem[rd_next];
      end else if (level_q == '0 && wr_en) begin
         head_d = avg;
      end

      overflow_d = (enable && !enable_q) ? 1'b0 : overflow_q;
      if (push && full && !pop)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         head_q     <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         head_q     <= head_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr_q] <= avg;
   end

   assign out_data   = head_q;
   assign out_valid  = (level_q != '0);
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_iir_decimator_fifo.sv
// Directed bench for iir_decimator_fifo: expected averages queued at stimulus time, checked by a pop monitor.
module tb_iir_decimator_fifo;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic               data_valid;
   logic signed [63:0] data;
   logic               out_ready;
   logic signed [63:0] out_data;
   logic               out_valid;
   logic [4:0]         fifo_level;
   logic               overflow;
   logic [6:0]         sample_cnt;

   int tests = 0;
   int fails = 0;
   logic signed [63:0] exp_q[$];

   iir_decimator_fifo #(.DECIM_LOG2(6), .FIFO_ADDR_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .data_valid (data_valid),
      .data       (data),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .sample_cnt (sample_cnt)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Scoreboard: every accepted pop must match the oldest expected average.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got %0d expected no output", out_data);
         end else begin
            chk("pop_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic signed [63:0] v);
      data_valid = 1'b1;
      data       = v;
      @(posedge clock);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic send_n(input int n, input logic signed [63:0] v);
      for (int i = 0; i < n; i++) send(v);
   endtask

   task automatic wait_empty(input int bound);
      out_ready = 1'b1;
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0 && fifo_level == 0) break;
         @(posedge clock);
         #1;
      end
      chk("drain_level", 64'(fifo_level), 64'd0);
      chk("drain_missing", 64'(exp_q.size()), 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; data_valid = 1'b0; data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // 1: block of +1000, visible one cycle after the 64th sample
      out_ready = 1'b1;
      send_n(10, 1000);
      chk("t1_cnt10", 64'(sample_cnt), 64'd10);
      send_n(53, 1000);
      chk("t1_valid_before", 64'(out_valid), 64'd0);
      exp_q.push_back(1000);
      send(1000);
      chk("t1_valid_after", 64'(out_valid), 64'd1);
      chk("t1_head", out_data, 64'sd1000);
      @(posedge clock);
      #1;
      chk("t1_valid_drained", 64'(out_valid), 64'd0);

      // 2: floor rounding of negative sums
      exp_q.push_back(-1);
      send_n(63, -1);
      send(0);
      exp_q.push_back(-5);
      send_n(64, -5);
      wait_empty(10);

      // 3: overflow, 17th block lost
      for (int k = 1; k <= 17; k++) begin
         if (k <= 16) exp_q.push_back(64'(k));
         send_n(64, 64'(k));
         if (k == 16) begin
            chk("t3_level16", 64'(fifo_level), 64'd16);
            chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
         end
      end
      chk("t3_level_full", 64'(fifo_level), 64'd16);
      chk("t3_overflow", 64'(overflow), 64'd1);
      chk("t3_head", out_data, 64'sd1);
      wait_empty(40);
      chk("t3_ovf_sticky", 64'(overflow), 64'd1);

      // overflow clears on a registered rising edge of enable
      enable = 1'b0;
      @(posedge clock);
      #1;
      chk("ovf_hold_disabled", 64'(overflow), 64'd1);
      enable = 1'b1;
      @(posedge clock);
      #1;
      chk("ovf_cleared", 64'(overflow), 64'd0);

      // 4: push and pop in the same cycle while full
      for (int k = 1; k <= 16; k++) begin
         exp_q.push_back(64'(k));
         send_n(64, 64'(k));
      end
      exp_q.push_back(17);
      send_n(63, 17);
      out_ready = 1'b1;
      send(17);
      out_ready = 1'b0;
      chk("t4_level", 64'(fifo_level), 64'd16);
      chk("t4_overflow", 64'(overflow), 64'd0);
      chk("t4_head", out_data, 64'sd2);
      wait_empty(40);

      // 5: reset mid-block discards the partial sum
      send_n(30, 9);
      chk("t5_cnt30", 64'(sample_cnt), 64'd30);
      reset = 1'b0;
      #2;
      chk("t5_cnt_rst", 64'(sample_cnt), 64'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      exp_q.push_back(7);
      send_n(64, 7);
      chk("t5_level", 64'(fifo_level), 64'd1);
      chk("t5_overflow", 64'(overflow), 64'd0);
      chk("t5_head", out_data, 64'sd7);
      wait_empty(10);
      chk("t5_hold_head", out_data, 64'sd7);

      // 6: disable mid-block, FIFO still drains, inputs ignored
      exp_q.push_back(11);
      send_n(64, 11);
      exp_q.push_back(12);
      send_n(64, 12);
      send_n(40, 5);
      chk("t6_level2", 64'(fifo_level), 64'd2);
      chk("t6_cnt40", 64'(sample_cnt), 64'd40);
      enable = 1'b0;
      out_ready = 1'b1;
      data_valid = 1'b1;
      data = 99;
      repeat (4) begin
         @(posedge clock);
         #1;
      end
      chk("t6_cnt_cleared", 64'(sample_cnt), 64'd0);
      chk("t6_level_drained", 64'(fifo_level), 64'd0);
      data_valid = 1'b0;
      enable = 1'b1;
      exp_q.push_back(3);
      send_n(64, 3);
      wait_empty(10);
      chk("t6_overflow", 64'(overflow), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
